// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the never-stalling integer pipe and the handshaked
// long-latency unit onto one registered register-file write port.
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       int_valid,
    input  logic [ADDR_W-1:0]          int_addr,
    input  logic [DATA_W-1:0]          int_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [ADDR_W-1:0]          lu_addr,
    input  logic [DATA_W-1:0]          lu_data,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [$clog2(DEPTH):0]     lu_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic int_req, lu_live, fifo_empty, pop, bypass, push;

    // Full blocks acceptance even when the head pops this cycle, so ready
    // depends only on registered state (and reset).
    assign lu_ready   = (count_q < CNT_W'(DEPTH)) && rst_n;
    assign int_req    = int_valid && (int_addr != '0);
    assign lu_live    = lu_valid && lu_ready && (lu_addr != '0);
    assign fifo_empty = (count_q == '0);
    assign pop        = !int_req && !fifo_empty;
    assign bypass     = !int_req && fifo_empty && lu_live;
    assign push       = lu_live && !bypass;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (int_req) begin
            we_d    = 1'b1;
            waddr_d = int_addr;
            wdata_d = int_data;
        end else if (pop) begin
            we_d    = 1'b1;
            waddr_d = mem_q[head_q].addr;
            wdata_d = mem_q[head_q].data;
            head_d  = head_q + PTR_W'(1);
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = lu_addr;
            wdata_d = lu_data;
        end

        if (push) begin
            mem_d[tail_q] = '{addr: lu_addr, data: lu_data};
            tail_d        = tail_q + PTR_W'(1);
        end

        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Storage is intentionally not reset; occupancy alone marks valid entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign lu_count     = count_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that merges two result streams onto the single register-file write port: the in-order integer pipe (never stalls, highest priority) and the long-latency unit (loads, FPU, multiply/divide) with a valid/ready handshake. Long-latency results that lose arbitration are held in a small in-order FIFO. The write-port outputs are registered and drive the register file's write_enable / write_addr / write_data directly. Addresses 0–31 are x0–x31 and 32–63 are f0–f31; address 0 is never written.

## Interface
- DATA_W, 64, result/data width
- ADDR_W, 6, register address width (64 architectural registers)
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- int_valid  in  1  integer-pipe result valid this cycle (always accepted)
- int_addr  in  ADDR_W  integer-pipe destination register
- int_data  in  DATA_W  integer-pipe result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept a long-latency result
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- write_enable  out  1  registered register-file write strobe
- write_addr  out  ADDR_W  registered register-file write address
- write_data  out  DATA_W  registered register-file write data
- lu_count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Effective requests: int_req = int_valid && int_addr != 0. A long-latency beat transfers when lu_valid && lu_ready. If lu_addr == 0, the beat is accepted and discarded: it is not queued and does not use the port.
- lu_ready = (lu_count < DEPTH) && rst_n. When the FIFO is full, lu_ready stays 0 even if a pop occurs in the same cycle.
- Port selection each cycle, in strict priority order:
  1. int_req: the integer result is issued.
  2. Else, FIFO not empty: the FIFO head is issued and popped.
  3. Else, FIFO empty and a non-zero lu beat transfers: the beat is issued directly (bypass, no FIFO entry).
  4. Else: write_enable = 0 next cycle.
- Push rule: a transferred non-zero lu beat is pushed whenever it is not issued via bypass. This covers int_req high and FIFO non-empty. Push and pop in the same cycle leave lu_count unchanged.
- Ordering:
  - Long-latency results reach the port in acceptance order.
  - No ordering is enforced between the integer and long-latency streams. The issue logic guarantees it never has both in flight to the same register.
- FIFO: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in lu_count.
- While write_enable = 0, write_addr and write_data hold their previous values.

## Timing
- Reset (rst_n low, asynchronous):
  - write_enable = 0, write_addr = 0, write_data = 0.
  - lu_count = 0, head = tail = 0, lu_ready = 0.
  - FIFO storage is not reset.
- Deassertion: lu_ready may rise in the first cycle after rst_n goes high. Reset mid-operation flushes all queued results; they are lost.
- Latency: an input selected in cycle N appears on write_* in cycle N+1. The register file commits it at the edge ending cycle N+1.
  - Integer pipe: always 1 cycle.
  - Long-latency: 1 cycle when bypassing; otherwise 1 cycle after it reaches the FIFO head and int_req is low.
- Throughput: one register write per cycle maximum. Sustained int_req starves the FIFO. Backpressure to the long-latency unit is via lu_ready only.
- lu_count updates on the same edge as the push/pop that changes it.

## Test plan
- Reset then idle: rst_n low → write_enable=0, write_addr=0, lu_count=0, lu_ready=0. Release → lu_ready=1 next cycle, write_enable stays 0.
- Integer-only stream: int_valid with addr 5/data 0xA, then addr 33/data 0xB → write_* shows (5,0xA), then (33,0xB), one cycle later each. Then int_addr=0 → write_enable=0.
- Bypass: FIFO empty, int_valid=0, lu beat addr 40/data 0x1234 → next cycle write_enable=1, write_addr=40, write_data=0x1234, lu_count stays 0.
- Contention and order: int_valid held 6 cycles while lu sends addrs 1,2,3,4,5.
  - lu_count reaches 4; lu_ready=0 on the fifth beat, which is held by the producer.
  - After int drops, the port shows 1,2,3,4,5 in order, with no gaps.
- Full with simultaneous pop: FIFO full, int_valid=0, lu_valid=1 → head popped, lu_ready=0 that cycle, lu_count=3. The next cycle the beat is accepted and pushed.
- Mid-operation reset: 3 entries queued, rst_n pulsed low mid-cycle → outputs zero immediately, lu_count=0. No queued result appears after release.
